// File: rtl/wire_test_pkg.sv
// Shared types and constants for the wire-block test sequencer.
package wire_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_PATTERN = 16'h000A;

  typedef logic [3:0] step_t;

endpackage

// File: rtl/wire_test_step_timer.sv
// Hold/step counter: flags the last cycle of each step and the final step of a run.
module wire_test_step_timer
  import wire_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int NUM_STEPS   = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  restart,
  input  logic  advance,
  output logic  sample_pulse,
  output logic  last_step,
  output step_t step
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q;
  step_t         step_q;

  assign step         = step_q;
  assign last_step    = (step_q == step_t'(NUM_STEPS - 1));
  assign sample_pulse = advance && (hold_q == HOLD_LAST);

  // On the final sample the counters park; the next restart rewinds them.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      hold_q <= '0;
      step_q <= '0;
    end else if (advance) begin
      if (hold_q != HOLD_LAST) begin
        hold_q <= hold_q + HW'(1);
      end else if (!last_step) begin
        hold_q <= '0;
        step_q <= step_q + step_t'(1);
      end
    end
  end

endmodule

// File: rtl/wire_test_ctrl.sv
// Drives a bit pattern onto wire_a, checks both fanouts on each step's last cycle,
// and reports error count, first failing step and pass/fail.
module wire_test_ctrl
  import wire_test_pkg::*;
#(
  parameter int          HOLD_CYCLES = 20,
  parameter int          NUM_STEPS   = 4,
  parameter logic [15:0] PATTERN     = DEFAULT_PATTERN,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             wire_a,
  input  logic             wire_b,
  input  logic             wire_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_step,
  output logic [1:0]       dbg_state
);

  state_t state_q, state_d;
  logic   restart, advance, sample_pulse, last_step, fail_seen;
  step_t  step, next_step;
  logic [1:0]       mism;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  assign dbg_state = state_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign restart   = (state_q == ST_IDLE) && start;
  assign advance   = (state_q == ST_RUN);
  assign next_step = step + step_t'(1);

  wire_test_step_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .NUM_STEPS   (NUM_STEPS)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .advance      (advance),
    .sample_pulse (sample_pulse),
    .last_step    (last_step),
    .step         (step)
  );

  // Mismatch count for this cycle, added with saturation at all-ones.
  assign mism     = {1'b0, wire_b ^ wire_a} + {1'b0, wire_c ^ wire_a};
  assign err_sum  = {1'b0, err_count} + (ERR_W+1)'(mism);
  assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (sample_pulse && last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wire_a          <= 1'b0;
      err_count       <= '0;
      pass            <= 1'b0;
      first_fail_step <= '0;
      fail_seen       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        wire_a          <= PATTERN[0];
        err_count       <= '0;
        pass            <= 1'b0;
        first_fail_step <= '0;
        fail_seen       <= 1'b0;
      end else if (sample_pulse) begin
        err_count <= err_next;
        if ((mism != 2'd0) && !fail_seen) begin
          first_fail_step <= step;
          fail_seen       <= 1'b1;
        end
        if (last_step) begin
          wire_a <= 1'b0;
          pass   <= (err_next == '0);
        end else begin
          wire_a <= PATTERN[next_step];
        end
      end
    end
  end

endmodule
